sram_arbiter: RTL and testbench

//  Two-port arbiter that shares the single sram_ctrl request interface between requester 0
//  (mem_ctrl, the UART loader) and requester 1 (graphics pipeline vertex/readback fetch).

---
 rtl/sram_arbiter_pkg.sv | 12 +
 rtl/sram_arbiter_rr_arb2.sv | 13 +
 rtl/sram_arbiter.sv | 111 +++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM state encoding and SRAM bus widths for the SRAM arbiter.
package sram_arbiter_pkg;
    localparam int SRAM_AW = 22;
    localparam int SRAM_DW = 16;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_WR,
        S_WAIT_RD,
        S_RECOVER
    } state_t;
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on contention the side not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic any
);
    always_comb begin
        grant = (req0 && req1) ? !last : req1;
        any   = req0 || req1;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_ctrl request port between two requesters, round-robin,
// one transaction in flight, with fixed write hold time and read timeout.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WR_LAT = 8,
    parameter int RD_TMO = 64,
    parameter bit PRIO0  = 1'b1
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iReqValid0,
    input  logic               iReqWrite0,
    input  logic [SRAM_AW-1:0] iReqAddr0,
    input  logic [SRAM_DW-1:0] iReqData0,
    input  logic               iReqValid1,
    input  logic               iReqWrite1,
    input  logic [SRAM_AW-1:0] iReqAddr1,
    input  logic [SRAM_DW-1:0] iReqData1,
    output logic               oAck0,
    output logic               oAck1,
    output logic [SRAM_DW-1:0] oRdData0,
    output logic [SRAM_DW-1:0] oRdData1,
    output logic               oErr0,
    output logic               oErr1,
    output logic [SRAM_AW-1:0] oAddress,
    output logic [SRAM_DW-1:0] oData,
    output logic               oValidRequest,
    output logic               oWrite,
    input  logic [SRAM_DW-1:0] iData,
    input  logic               iValidRead,
    output logic               oBusy
);
    localparam int CW = $clog2(WR_LAT > RD_TMO ? WR_LAT : RD_TMO) + 1;

    state_t             state, nextState;
    logic [CW-1:0]      count;
    logic               lastGrant, winner, pick, anyReq;
    logic               wrDone, rdDone, rdTmo, done;
    logic [SRAM_AW-1:0] addrReg;
    logic [SRAM_DW-1:0] dataReg;
    logic               writeReg;

    rr_arb2 uArb (
        .req0 (iReqValid0),
        .req1 (iReqValid1),
        .last (lastGrant),
        .grant(pick),
        .any  (anyReq)
    );

    // Data arriving on the timeout cycle wins, so rdTmo excludes iValidRead.
    always_comb begin
        wrDone    = (state == S_WAIT_WR) && (count == CW'(WR_LAT - 1));
        rdDone    = (state == S_WAIT_RD) && iValidRead;
        rdTmo     = (state == S_WAIT_RD) && !iValidRead && (count == CW'(RD_TMO - 1));
        done      = wrDone || rdDone || rdTmo;
        nextState = state;
        case (state)
            S_IDLE:               nextState = anyReq ? S_ISSUE : S_IDLE;
            S_ISSUE:              nextState = writeReg ? S_WAIT_WR : S_WAIT_RD;
            S_WAIT_WR, S_WAIT_RD: nextState = done ? S_RECOVER : state;
            default:              nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) state <= S_IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            count     <= '0;
            lastGrant <= PRIO0;
            winner    <= 1'b0;
            addrReg   <= '0;
            dataReg   <= '0;
            writeReg  <= 1'b0;
            oAck0     <= 1'b0;
            oAck1     <= 1'b0;
            oErr0     <= 1'b0;
            oErr1     <= 1'b0;
            oRdData0  <= '0;
            oRdData1  <= '0;
        end else begin
            count <= (state == S_WAIT_WR || state == S_WAIT_RD) ? count + CW'(1) : '0;
            oAck0 <= done && !winner;
            oAck1 <= done && winner;
            oErr0 <= rdTmo && !winner;
            oErr1 <= rdTmo && winner;
            if ((rdDone || rdTmo) && !winner) oRdData0 <= rdTmo ? '0 : iData;
            if ((rdDone || rdTmo) && winner)  oRdData1 <= rdTmo ? '0 : iData;
            if (state == S_IDLE && anyReq) begin
                winner    <= pick;
                lastGrant <= pick;
                addrReg   <= pick ? iReqAddr1 : iReqAddr0;
                dataReg   <= pick ? iReqData1 : iReqData0;
                writeReg  <= pick ? iReqWrite1 : iReqWrite0;
            end
        end
    end

    always_comb begin
        oValidRequest = (state == S_ISSUE) || (state == S_WAIT_WR) || (state == S_WAIT_RD);
        oBusy         = state != S_IDLE;
        oAddress      = addrReg;
        oData         = dataReg;
        oWrite        = writeReg;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed requests with a response/bus scoreboard drained by independent monitors.
module tb_sram_arbiter;
    localparam int WR_LAT = 8;
    localparam int RD_TMO = 64;

    typedef struct {int port; logic err; logic read; logic [15:0] data;} resp_t;
    typedef struct {logic [21:0] addr; logic [15:0] data; logic write; int len;} bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid[2];
    logic        reqWrite[2];
    logic [21:0] reqAddr[2];
    logic [15:0] reqData[2];
    logic        oAck0, oAck1, oErr0, oErr1, oValidRequest, oWrite, oBusy, iValidRead;
    logic [15:0] oRdData0, oRdData1, oData, iData;
    logic [21:0] oAddress;

    resp_t       respQ[$];
    bus_t        busQ[$];
    int          errors = 0;
    int          checks = 0;
    int          rdLat = -1;
    logic [15:0] rdValue = 16'h0;

    always #5 clk = ~clk;

    sram_arbiter #(.WR_LAT(WR_LAT), .RD_TMO(RD_TMO), .PRIO0(1'b1)) dut (
        .iClock(clk), .iReset(rst),
        .iReqValid0(reqValid[0]), .iReqWrite0(reqWrite[0]), .iReqAddr0(reqAddr[0]), .iReqData0(reqData[0]),
        .iReqValid1(reqValid[1]), .iReqWrite1(reqWrite[1]), .iReqAddr1(reqAddr[1]), .iReqData1(reqData[1]),
        .oAck0(oAck0), .oAck1(oAck1), .oRdData0(oRdData0), .oRdData1(oRdData1),
        .oErr0(oErr0), .oErr1(oErr1), .oAddress(oAddress), .oData(oData),
        .oValidRequest(oValidRequest), .oWrite(oWrite), .iData(iData),
        .iValidRead(iValidRead), .oBusy(oBusy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expBus(input logic [21:0] a, input logic [15:0] d, input logic w, input int len);
        bus_t b;
        b.addr = a; b.data = d; b.write = w; b.len = len;
        busQ.push_back(b);
    endtask

    task automatic expResp(input int p, input logic err, input logic rd, input logic [15:0] d);
        resp_t r;
        r.port = p; r.err = err; r.read = rd; r.data = d;
        respQ.push_back(r);
    endtask

    task automatic issue(input int p, input logic w, input logic [21:0] a, input logic [15:0] d);
        reqValid[p] = 1'b1; reqWrite[p] = w; reqAddr[p] = a; reqData[p] = d;
    endtask

    task automatic waitAck(input int p, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 1 ? oAck1 : oAck0) && n < 300);
        if (!(p == 1 ? oAck1 : oAck0)) check("ack_timeout", 64'd0, 64'd1);
    endtask

    // SRAM model: k counts cycles of an active read request, ISSUE being k=0.
    initial begin
        int k;
        k = 0;
        iValidRead = 1'b0;
        iData = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (oValidRequest && !oWrite && !rst) begin
                iValidRead = (k == rdLat);
                iData = (k == rdLat) ? rdValue : 16'hDEAD;
                k++;
            end else begin
                iValidRead = 1'b0;
                iData = 16'hDEAD;
                k = 0;
            end
        end
    end

    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (oAck0 && oAck1) check("dual_ack", 64'd1, 64'd0);
                if (!oAck0 && !oAck1 && (oErr0 || oErr1)) check("stray_err", {oErr1, oErr0}, 64'd0);
                if (oAck0 || oAck1) begin
                    if (respQ.size() == 0) check("unexpected_ack", {oAck1, oAck0}, 64'd0);
                    else begin
                        e = respQ.pop_front();
                        check("ack_port", oAck1 ? 64'd1 : 64'd0, 64'(e.port));
                        check("ack_err", e.port == 1 ? oErr1 : oErr0, e.err);
                        if (e.read) check("rd_data", e.port == 1 ? oRdData1 : oRdData0, e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic        active, w;
        int          len;
        logic [21:0] a;
        logic [15:0] d;
        bus_t        e;
        active = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            if (rst) active = 1'b0;
            else if (oValidRequest) begin
                if (!active) begin
                    active = 1'b1; len = 0; a = oAddress; d = oData; w = oWrite;
                end else if (oAddress !== a || oData !== d || oWrite !== w)
                    check("bus_stable", {oWrite, oData, oAddress}, {w, d, a});
                len++;
            end else if (active) begin
                active = 1'b0;
                if (busQ.size() == 0) check("unexpected_bus", 64'(a), 64'd0);
                else begin
                    e = busQ.pop_front();
                    check("bus_addr", a, e.addr);
                    check("bus_write", w, e.write);
                    if (w) check("bus_data", d, e.data);
                    check("bus_len", len, e.len);
                end
            end
        end
    end

    initial begin
        int n, n0, n1;
        for (int p = 0; p < 2; p++) begin
            reqValid[p] = 1'b0; reqWrite[p] = 1'b0; reqAddr[p] = '0; reqData[p] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_ctrl", {oAck0, oAck1, oErr0, oErr1, oValidRequest, oWrite, oBusy}, 64'd0);
        check("rst_bus", {oAddress, oData}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        expBus(22'h000123, 16'hBEEF, 1'b1, WR_LAT + 1);
        expResp(0, 1'b0, 1'b0, 16'h0);
        issue(0, 1'b1, 22'h000123, 16'hBEEF);
        waitAck(0, n);
        check("wr_latency", n, WR_LAT + 2);
        reqValid[0] = 1'b0;
        @(negedge clk);

        rdLat = 5; rdValue = 16'h1234;
        expBus(22'h3FFFFF, 16'h0, 1'b0, 6);
        expResp(1, 1'b0, 1'b1, 16'h1234);
        issue(1, 1'b0, 22'h3FFFFF, 16'h0);
        waitAck(1, n);
        check("rd_latency", n, 7);
        reqValid[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            expBus(22'(22'h100 + i), 16'(16'hA000 + i), 1'b1, WR_LAT + 1);
            expResp(0, 1'b0, 1'b0, 16'h0);
            expBus(22'(22'h200 + i), 16'(16'hB000 + i), 1'b1, WR_LAT + 1);
            expResp(1, 1'b0, 1'b0, 16'h0);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(0, 1'b1, 22'(22'h100 + i), 16'(16'hA000 + i));
                    waitAck(0, n0);
                end
                reqValid[0] = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    issue(1, 1'b1, 22'(22'h200 + j), 16'(16'hB000 + j));
                    waitAck(1, n1);
                end
                reqValid[1] = 1'b0;
            end
        join
        @(negedge clk);

        rdLat = RD_TMO; rdValue = 16'h5A5A;
        expBus(22'h00ABCD, 16'h0, 1'b0, RD_TMO + 1);
        expResp(0, 1'b0, 1'b1, 16'h5A5A);
        issue(0, 1'b0, 22'h00ABCD, 16'h0);
        waitAck(0, n);
        reqValid[0] = 1'b0;
        @(negedge clk);

        rdLat = -1;
        expBus(22'h00ABCE, 16'h0, 1'b0, RD_TMO + 1);
        expResp(0, 1'b1, 1'b1, 16'h0000);
        issue(0, 1'b0, 22'h00ABCE, 16'h0);
        waitAck(0, n);
        check("tmo_latency", n, RD_TMO + 2);
        reqValid[0] = 1'b0;
        @(negedge clk);

        expBus(22'h0000AA, 16'h1111, 1'b1, WR_LAT + 1);
        expResp(0, 1'b0, 1'b0, 16'h0);
        issue(0, 1'b1, 22'h0000AA, 16'h1111);
        @(negedge clk);
        reqValid[0] = 1'b0; reqAddr[0] = 22'h0000BB; reqData[0] = 16'h2222;
        waitAck(0, n);
        @(negedge clk);

        issue(0, 1'b1, 22'h000777, 16'h7777);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", oBusy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {oAck0, oAck1, oErr0, oErr1, oValidRequest, oWrite, oBusy}, 64'd0);
        check("mid_rst_bus", {oAddress, oData}, 64'd0);
        check("mid_rst_rd", {oRdData0, oRdData1}, 64'd0);
        reqValid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {oBusy, oValidRequest}, 64'd0);

        expBus(22'h000010, 16'hC0DE, 1'b1, WR_LAT + 1);
        expResp(0, 1'b0, 1'b0, 16'h0);
        expBus(22'h000020, 16'hD00D, 1'b1, WR_LAT + 1);
        expResp(1, 1'b0, 1'b0, 16'h0);
        issue(0, 1'b1, 22'h000010, 16'hC0DE);
        issue(1, 1'b1, 22'h000020, 16'hD00D);
        fork
            begin waitAck(0, n0); reqValid[0] = 1'b0; end
            begin waitAck(1, n1); reqValid[1] = 1'b0; end
        join

        for (int t = 0; t < 100 && (respQ.size() + busQ.size()) > 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("queues_empty", 64'(respQ.size() + busQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
